// File: rtl/bus_mem_slave.sv
// Word-organised RAM bus responder with fixed wait-state latency and byte/half/word lanes.
// Optional error checking (misalignment, range, illegal size) is enabled by BUS_MEM_ERR_EN.
module bus_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [31:0] bus_addr,
  input  logic [2:0]  bus_tsize,
  input  logic [31:0] bus_wrdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  tsize_q;
  logic        wr_q, both_q;

  logic        capture;
  logic [32:0] diff;
  logic [AW-1:0] idx;
  logic        is_b, is_h, is_w;
  logic [1:0]  lane;
  logic        err;
  logic [31:0] rword, rshift, wsh;
  logic [3:0]  bmask;
  logic        we;

  logic [31:0] mem [DEPTH_WORDS];

  assign capture = (state_q == StIdle) && (bus_rd || bus_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      tsize_q <= 3'd0;
      wr_q    <= 1'b0;
      both_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= bus_addr;
        wdata_q <= bus_wrdata;
        tsize_q <= bus_tsize;
        wr_q    <= bus_wr;
        both_q  <= bus_rd & bus_wr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Illegal sizes fall through to word handling.
  assign is_b = (tsize_q == 3'b000) || (tsize_q == 3'b100);
  assign is_h = (tsize_q == 3'b001) || (tsize_q == 3'b101);
  assign is_w = !is_b && !is_h;

  assign diff = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign idx  = diff[AW+1:2];

`ifdef BUS_MEM_ERR_EN
  logic legal_ts, misalign, out_range;
  assign legal_ts  = (tsize_q == 3'b000) || (tsize_q == 3'b001) || (tsize_q == 3'b010) ||
                     (tsize_q == 3'b100) || (tsize_q == 3'b101);
  assign misalign  = (is_h && addr_q[0]) || (is_w && (addr_q[1:0] != 2'b00));
  // An address below the base wraps into diff[32], which also lands out of range.
  assign out_range = (diff >= SPAN);
  assign err       = !legal_ts || both_q || misalign || out_range;
  assign lane      = addr_q[1:0];
`else
  logic unused_bits;
  assign unused_bits = ^{diff[32:AW+2], diff[1:0], both_q, SPAN};
  assign err         = 1'b0;
  // Force alignment: halves drop addr[0], words drop addr[1:0].
  assign lane        = is_w ? 2'b00 : (is_h ? {addr_q[1], 1'b0} : addr_q[1:0]);
`endif

  assign rword  = mem[idx];
  assign rshift = rword >> {lane, 3'b000};
  assign wsh    = wdata_q << {lane, 3'b000};

  always_comb begin
    bmask = 4'b1111;
    if (is_b) begin
      bmask = 4'b0001 << lane;
    end else if (is_h) begin
      bmask = 4'b0011 << lane;
    end
  end

  always_comb begin
    bus_rdata = 32'd0;
    if ((state_q == StResp) && !wr_q && !err) begin
      if (is_b) begin
        bus_rdata = {24'd0, rshift[7:0]};
      end else if (is_h) begin
        bus_rdata = {16'd0, rshift[15:0]};
      end else begin
        bus_rdata = rshift;
      end
    end
  end

  assign bus_ack = (state_q == StResp);
  assign bus_err = (state_q == StResp) && err;
  assign busy    = (state_q != StIdle);
  assign we      = (state_q == StResp) && wr_q && !err;

  // RAM is deliberately not reset; rst only blocks a commit racing the reset edge.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bmask[i]) begin
          mem[idx][8*i +: 8] <= wsh[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Scoreboard bench for bus_mem_slave: one instance with one wait state, one with none.
module tb_bus_mem_slave;

  localparam logic [2:0] TS_B   = 3'b000;
  localparam logic [2:0] TS_H   = 3'b001;
  localparam logic [2:0] TS_W   = 3'b010;
  localparam logic [2:0] TS_BAD = 3'b011;
  localparam logic [2:0] TS_BU  = 3'b100;
  localparam logic [2:0] TS_HU  = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [2:0]  tsize [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack [2];
  logic        err [2];
  logic        busy [2];

  always #5 clk = ~clk;

  bus_mem_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .bus_rd(rd[0]), .bus_wr(wr[0]), .bus_addr(addr[0]),
    .bus_tsize(tsize[0]), .bus_wrdata(wdata[0]), .bus_rdata(rdata[0]), .bus_ack(ack[0]),
    .bus_err(err[0]), .busy(busy[0])
  );

  bus_mem_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .bus_rd(rd[1]), .bus_wr(wr[1]), .bus_addr(addr[1]),
    .bus_tsize(tsize[1]), .bus_wrdata(wdata[1]), .bus_rdata(rdata[1]), .bus_ack(ack[1]),
    .bus_err(err[1]), .busy(busy[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic mon_on = 1'b0;

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      if (ack[0] === 1'b1) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL ws1 unexpected ack: got ack=1 expected no ack");
        end else begin
          e = q0.pop_front();
          check32({e.name, " rdata"}, rdata[0], e.rdata);
          check32({e.name, " err"}, 32'(err[0]), 32'(e.err));
        end
      end else begin
        check32("ws1 idle rdata", rdata[0], 32'd0);
      end
      if (ack[1] === 1'b1) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL ws0 unexpected ack: got ack=1 expected no ack");
        end else begin
          e = q1.pop_front();
          check32({e.name, " rdata"}, rdata[1], e.rdata);
          check32({e.name, " err"}, 32'(err[1]), 32'(e.err));
        end
      end else begin
        check32("ws0 idle rdata", rdata[1], 32'd0);
      end
    end
  end

  task automatic push_exp(input int d, input logic [31:0] r, input logic e, input string nm);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.name  = nm;
    if (d == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  // Issue one request, hold it until ack (bounded), then drop it and idle one cycle.
  task automatic do_op(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [2:0] ts, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input string nm);
    int   n;
    logic got;
    push_exp(d, exp_rd, exp_err, nm);
    rd[d] = r;
    wr[d] = w;
    addr[d] = a;
    tsize[d] = ts;
    wdata[d] = wd;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ack[d] === 1'b1) got = 1'b1;
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    check32({nm, " latency"}, 32'(n), (d == 0) ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] pat;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      addr[d] = 32'd0;
      tsize[d] = TS_W;
      wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check32("reset ack", 32'(ack[d]), 32'd0);
      check32("reset err", 32'(err[d]), 32'd0);
      check32("reset rdata", rdata[d], 32'd0);
      check32("reset busy", 32'(busy[d]), 32'd0);
    end
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    do_op(0, 0, 1, 32'h10, TS_W, 32'hDEADBEEF, 32'h0, 1'b0, "wr W 0x10");
    do_op(0, 1, 0, 32'h10, TS_W, 32'h0, 32'hDEADBEEF, 1'b0, "rd W 0x10");
    do_op(0, 0, 1, 32'h11, TS_B, 32'hABCDEF5A, 32'h0, 1'b0, "wr B 0x11");
    do_op(0, 1, 0, 32'h10, TS_W, 32'h0, 32'hDEAD5AEF, 1'b0, "rd W after B");
    do_op(0, 1, 0, 32'h12, TS_H, 32'h0, 32'h0000DEAD, 1'b0, "rd H 0x12");
    do_op(0, 1, 0, 32'h11, TS_BU, 32'h0, 32'h0000005A, 1'b0, "rd BU 0x11");
    do_op(0, 1, 0, 32'h13, TS_B, 32'h0, 32'h000000DE, 1'b0, "rd B 0x13");
    do_op(0, 1, 0, 32'h10, TS_HU, 32'h0, 32'h00005AEF, 1'b0, "rd HU 0x10");
    do_op(0, 0, 1, 32'h14, TS_W, 32'h01020304, 32'h0, 1'b0, "wr W 0x14");
    do_op(0, 0, 1, 32'h16, TS_H, 32'h0000CAFE, 32'h0, 1'b0, "wr H 0x16");
    do_op(0, 1, 0, 32'h14, TS_W, 32'h0, 32'hCAFE0304, 1'b0, "rd W after H");

`ifdef BUS_MEM_ERR_EN
    do_op(0, 1, 0, 32'h13, TS_W, 32'h0, 32'h0, 1'b1, "rd W misaligned");
    do_op(0, 1, 0, 32'h11, TS_H, 32'h0, 32'h0, 1'b1, "rd H misaligned");
    do_op(0, 1, 0, 32'h10, TS_BAD, 32'h0, 32'h0, 1'b1, "rd bad tsize");
    do_op(0, 0, 1, 32'h0, TS_W, 32'h0BADF00D, 32'h0, 1'b0, "wr W 0x0");
    do_op(0, 0, 1, 32'h1000, TS_W, 32'hFFFFFFFF, 32'h0, 1'b1, "wr out of range");
    do_op(0, 1, 0, 32'h0, TS_W, 32'h0, 32'h0BADF00D, 1'b0, "rd word 0 intact");
    do_op(0, 1, 1, 32'h10, TS_W, 32'hFFFFFFFF, 32'h0, 1'b1, "rd+wr together");
    do_op(0, 1, 0, 32'h10, TS_W, 32'h0, 32'hDEAD5AEF, 1'b0, "rd after rd+wr");
`else
    do_op(0, 0, 1, 32'h13, TS_W, 32'h12345678, 32'h0, 1'b0, "wr W misaligned");
    do_op(0, 1, 0, 32'h10, TS_W, 32'h0, 32'h12345678, 1'b0, "rd W force-aligned");
    do_op(0, 1, 0, 32'h13, TS_H, 32'h0, 32'h00001234, 1'b0, "rd H force-aligned");
    do_op(0, 1, 0, 32'h10, TS_BAD, 32'h0, 32'h12345678, 1'b0, "rd bad tsize as W");
    do_op(0, 0, 1, 32'h0, TS_W, 32'h11110000, 32'h0, 1'b0, "wr W 0x0");
    do_op(0, 0, 1, 32'h1000, TS_W, 32'h0BADF00D, 32'h0, 1'b0, "wr W wrap");
    do_op(0, 1, 0, 32'h0, TS_W, 32'h0, 32'h0BADF00D, 1'b0, "rd word 0 wrapped");
    do_op(0, 1, 1, 32'h10, TS_W, 32'hA5A5A5A5, 32'h0, 1'b0, "rd+wr as write");
    do_op(0, 1, 0, 32'h10, TS_W, 32'h0, 32'hA5A5A5A5, 1'b0, "rd after rd+wr");
`endif

    // Zero wait states: a held read is captured, acked, skipped once, then recaptured.
    do_op(1, 0, 1, 32'h10, TS_W, 32'hC0FFEE00, 32'h0, 1'b0, "ws0 wr W 0x10");
    push_exp(1, 32'hC0FFEE00, 1'b0, "ws0 b2b rd1");
    push_exp(1, 32'hC0FFEE00, 1'b0, "ws0 b2b rd2");
    rd[1] = 1'b1;
    addr[1] = 32'h10;
    tsize[1] = TS_W;
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check32("ws0 b2b ack", 32'(ack[1]), 32'(pat[i]));
      check32("ws0 b2b busy", 32'(busy[1]), 32'(pat[i]));
      if (i == 2) rd[1] = 1'b0;
    end
    @(posedge clk);
    #1;

    // Reset in the wait state of a write must drop it without touching RAM.
    do_op(0, 0, 1, 32'h20, TS_W, 32'h11111111, 32'h0, 1'b0, "wr W 0x20 old");
    wr[0] = 1'b1;
    addr[0] = 32'h20;
    tsize[0] = TS_W;
    wdata[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    check32("mid-txn busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check32("rst ack", 32'(ack[0]), 32'd0);
    check32("rst busy", 32'(busy[0]), 32'd0);
    check32("rst rdata", rdata[0], 32'd0);
    check32("rst err", 32'(err[0]), 32'd0);
    wr[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_op(0, 1, 0, 32'h20, TS_W, 32'h0, 32'h11111111, 1'b0, "rd 0x20 after reset");

    repeat (3) @(posedge clk);
    #1;
    check32("ws1 queue drained", 32'(q0.size()), 32'd0);
    check32("ws0 queue drained", 32'(q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
Bus responder (slave end) for the core's load/store bus. It decodes one address window, holds a word-organised RAM, and answers byte, half and word reads and writes with a fixed, parameterised wait-state latency. It sits behind the bus fabric as the data/instruction memory model and acts as the template for future peripheral slaves.

Parameters:
BASE_ADDR  32'h0000_0000  byte address of first RAM word; must be DEPTH_WORDS*4 aligned
DEPTH_WORDS  1024  number of 32-bit words; power of two, >=2
WAIT_STATES  1  idle cycles between request capture and ack; 0..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
bus_rd  in  1  read request; held by master until ack
bus_wr  in  1  write request; held by master until ack
bus_addr  in  32  byte address
bus_tsize  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
bus_wrdata  in  32  write data, right-justified (B in [7:0], H in [15:0])
bus_rdata  out  32  read data, right-justified, zero-extended; sign-extension is the core's job
bus_ack  out  1  one-cycle response strobe
bus_err  out  1  error qualifier, valid only with bus_ack
busy  out  1  high while a transaction is captured and not yet acked

Behaviour:
- Reset (async, rst=1): state IDLE, bus_ack=0, bus_err=0, bus_rdata=0, busy=0, wait counter=0. RAM contents are not reset. Deassertion is synchronous to clk at the bench level.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE: when bus_rd|bus_wr, capture addr, tsize, wrdata and op into registers. Go to WAIT with counter=WAIT_STATES; if WAIT_STATES==0, go directly to RESP. busy=1 from the next cycle.
- WAIT: decrement the counter each cycle; at 1, go to RESP.
- RESP: for exactly one cycle, bus_ack=1, bus_err as computed, and bus_rdata valid. Writes commit to RAM on the clk edge that ends RESP, only when err=0. Then return to IDLE.
- Latency: the request seen in cycle N produces ack in cycle N+1+WAIT_STATES.
- Back-to-back: the request is still high during the ack cycle. It is not recaptured in that cycle; the earliest new capture is the cycle after ack (the master drops or changes the request after ack).
- bus_rd and bus_wr together in IDLE: treated as a write with err=1; RAM is unchanged.
- Lane select uses captured addr[1:0]:
  - B/BU: read byte = word[8*a+7:8*a]; write updates only that byte.
  - H/HU: lane a[1]; write updates those 16 bits.
  - W: full word.
- bus_rdata is 0 when not acking, on writes, and on err.
- Word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- tsize 011, 110 or 111: err=1.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and no RAM write occurs.

Optional Feature:
BUS_MEM_ERR_EN
- Defined:
  - err=1 on misalignment (H with addr[0]=1, W with addr[1:0]!=0).
  - err=1 when addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - err=1 on an illegal tsize or simultaneous rd/wr.
  - An erroring write leaves RAM untouched; an erroring read returns 0.
- Undefined:
  - bus_err is tied 0.
  - Misaligned accesses are force-aligned (addr[0] cleared for H, addr[1:0] cleared for W).
  - Out-of-range addresses wrap modulo the RAM size.
  - Illegal tsize behaves as W; simultaneous rd/wr behaves as a write.

Test Plan:
- WAIT_STATES=1: write W 0xDEADBEEF @0x10, then read W @0x10 -> ack two cycles after each request, rdata=0xDEADBEEF, err=0.
- After the previous test: write B 0x5A @0x11, then read W @0x10 -> 0xDEAD5AEF. Read H @0x12 -> 0x0000DEAD. Read BU @0x11 -> 0x0000005A.
- WAIT_STATES=0: read request held for two consecutive transactions -> ack in the cycle after capture, exactly one ack per capture, busy pulses correctly.
- With BUS_MEM_ERR_EN: read W @0x13 -> ack with err=1, rdata=0. Write W @BASE+4*DEPTH_WORDS -> err=1, and a readback of word 0 is unchanged.
- Without BUS_MEM_ERR_EN: write W 0x12345678 @0x13 -> err=0; read W @0x10 -> 0x12345678.
- Assert rst in the WAIT state of a write 0xFFFFFFFF @0x20 -> no ack, outputs 0 immediately; read @0x20 after release returns the old value.
